// File: rtl/pcs_tx_sequencer_pkg.sv
// pcs_tx_sequencer_pkg
//   PCS code-group constants shared by the transmit, receive and sync blocks.
//   K values are the octets handed to the 8b/10b encoder with is_k=1,
//   D values with is_k=0.
package pcs_tx_sequencer_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;  // comma, first half of an idle pair
  localparam logic [7:0] K27_7 = 8'hFB;  // /S/ start of packet
  localparam logic [7:0] K29_7 = 8'hFD;  // /T/ end of packet
  localparam logic [7:0] K23_7 = 8'hF7;  // /R/ carrier extend / pad
  localparam logic [7:0] K30_7 = 8'hFE;  // /V/ error propagation
  localparam logic [7:0] D5_6  = 8'hC5;  // /I1/ second half, flips disparity
  localparam logic [7:0] D16_2 = 8'h50;  // /I2/ second half, keeps disparity

endpackage

// File: rtl/pcs_tx_sequencer.sv
// pcs_tx_sequencer
//   Transmit ordered-set controller. Samples the GMII byte stream each clock
//   and picks the next code-group for the 8b/10b encoder: idle pair, /S/,
//   data, /V/, or /T/R/(R). Keeps /S/ and K28.5 on even slots.
//
// Ports
//   clk, reset     clock, synchronous active-low reset
//   tx_en, tx_er   GMII transmit enable / error
//   txd[7:0]       GMII transmit data
//   rd_pos         encoder running disparity, 1 = positive
//   tx_code[7:0]   octet for the encoder
//   tx_is_k        tx_code is a K code-group
//   tx_even        tx_code occupies an even slot
//   transmitting   1 during START and DATA slots
module pcs_tx_sequencer
  import pcs_tx_sequencer_pkg::*;
#(
  parameter bit IDLE_I1_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_en,
  input  logic       tx_er,
  input  logic [7:0] txd,
  input  logic       rd_pos,
  output logic [7:0] tx_code,
  output logic       tx_is_k,
  output logic       tx_even,
  output logic       transmitting
);

  // state holds the code-group currently on tx_code; every edge computes the
  // next state and registers that state's code-group alongside it.
  typedef enum logic [6:0] {
    IDLE_K = 7'b0000001,
    IDLE_D = 7'b0000010,
    START  = 7'b0000100,
    DATA   = 7'b0001000,
    END_T  = 7'b0010000,
    END_R  = 7'b0100000,
    END_R2 = 7'b1000000
  } state_t;

  state_t state;
  logic   i1_pend;  // first idle after a packet may use /I1/

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE_K;
      tx_code      <= K28_5;
      tx_is_k      <= 1'b1;
      tx_even      <= 1'b1;
      transmitting <= 1'b0;
      i1_pend      <= 1'b0;
    end else begin
      tx_even      <= ~tx_even;
      transmitting <= 1'b0;
      case (state)
        IDLE_K: begin
          // rd_pos sampled now is the disparity seen during this K28.5
          state   <= IDLE_D;
          tx_code <= (i1_pend && rd_pos) ? D5_6 : D16_2;
          tx_is_k <= 1'b0;
          i1_pend <= 1'b0;
        end
        IDLE_D: begin
          if (tx_en) begin
            state        <= START;
            tx_code      <= K27_7;
            tx_is_k      <= 1'b1;
            transmitting <= 1'b1;
          end else begin
            state   <= IDLE_K;
            tx_code <= K28_5;
            tx_is_k <= 1'b1;
          end
        end
        START, DATA: begin
          // the byte sampled while entering START is dropped (preamble)
          if (tx_en) begin
            state        <= DATA;
            tx_code      <= tx_er ? K30_7 : txd;
            tx_is_k      <= tx_er;
            transmitting <= 1'b1;
          end else begin
            state   <= END_T;
            tx_code <= K29_7;
            tx_is_k <= 1'b1;
          end
        end
        END_T: begin
          state   <= END_R;
          tx_code <= K23_7;
          tx_is_k <= 1'b1;
          if (IDLE_I1_EN) i1_pend <= 1'b1;
        end
        END_R: begin
          // an /R/ on an even slot needs a second /R/ so K28.5 lands even
          if (tx_even) begin
            state   <= END_R2;
            tx_code <= K23_7;
            tx_is_k <= 1'b1;
          end else begin
            state   <= IDLE_K;
            tx_code <= K28_5;
            tx_is_k <= 1'b1;
          end
        end
        END_R2: begin
          state   <= IDLE_K;
          tx_code <= K28_5;
          tx_is_k <= 1'b1;
        end
        default: begin
          state   <= IDLE_K;
          tx_code <= K28_5;
          tx_is_k <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcs_tx_sequencer.sv
// tb_pcs_tx_sequencer
//   Directed vectors for pcs_tx_sequencer. dut_a has /I1/ enabled, dut_b has
//   it disabled; both see the same stimulus.
module tb_pcs_tx_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_en, tx_er, rd_pos;
  logic [7:0] txd;
  logic [7:0] a_code, b_code;
  logic       a_k, a_even, a_tr, b_k, b_even, b_tr;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  always #5 clk = ~clk;

  pcs_tx_sequencer #(.IDLE_I1_EN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .tx_en(tx_en), .tx_er(tx_er), .txd(txd),
    .rd_pos(rd_pos), .tx_code(a_code), .tx_is_k(a_k), .tx_even(a_even),
    .transmitting(a_tr)
  );

  pcs_tx_sequencer #(.IDLE_I1_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .tx_en(tx_en), .tx_er(tx_er), .txd(txd),
    .rd_pos(rd_pos), .tx_code(b_code), .tx_is_k(b_k), .tx_even(b_even),
    .transmitting(b_tr)
  );

  typedef struct {
    logic       en;
    logic       er;
    logic [7:0] d;
    logic       rd;
    logic [7:0] code;  // expected for dut_a
    logic       k;
    logic       even;
    logic       tr;
  } vec_t;

  vec_t tbl[$];

  function automatic void mk(input logic en, input logic er, input logic [7:0] d,
                             input logic rd, input logic [7:0] code,
                             input logic k, input logic even, input logic tr);
    vec_t v;
    v.en = en; v.er = er; v.d = d; v.rd = rd;
    v.code = code; v.k = k; v.even = even; v.tr = tr;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // K28.5 and /S/ must always occupy even slots
  always @(negedge clk) begin
    if (mon_en && reset) begin
      checks++;
      if (a_k && (a_code == 8'hBC || a_code == 8'hFB) && !a_even) begin
        failures++;
        $display("FAIL align code=%h even=%b expected even=1", a_code, a_even);
      end
    end
  end

  initial begin
    logic [7:0] exp_b;
    reset = 1'b0; tx_en = 1'b0; tx_er = 1'b0; txd = 8'h00; rd_pos = 1'b0;

    // reset state, held for two edges with tx_en asserted
    tx_en = 1'b1;
    step();
    step();
    chk("rst_code", -1, a_code, 8'hBC);
    chk("rst_k", -1, {7'd0, a_k}, 8'd1);
    chk("rst_even", -1, {7'd0, a_even}, 8'd1);
    chk("rst_tr", -1, {7'd0, a_tr}, 8'd0);
    tx_en = 1'b0;
    reset = 1'b1;
    mon_en = 1'b1;

    // 10 idle cycles; carrier extension (tx_er only) in row 2
    for (int i = 0; i < 5; i++) begin
      mk(0, (i == 1), 8'h0F, 0, 8'h50, 0, 0, 0);
      mk(0, 0,        8'h00, 0, 8'hBC, 1, 1, 0);
    end
    mk(0, 0, 8'h00, 0, 8'h50, 0, 0, 0);
    // packet from IDLE_D: 55 55 D5 01 02; R even -> /T/R/R/
    mk(1, 0, 8'h55, 0, 8'hFB, 1, 1, 1);
    mk(1, 0, 8'h55, 0, 8'h55, 0, 0, 1);
    mk(1, 0, 8'hD5, 0, 8'hD5, 0, 1, 1);
    mk(1, 0, 8'h01, 0, 8'h01, 0, 0, 1);
    mk(1, 0, 8'h02, 0, 8'h02, 0, 1, 1);
    mk(0, 0, 8'h00, 0, 8'hFD, 1, 0, 0);
    mk(0, 0, 8'h00, 0, 8'hF7, 1, 1, 0);
    mk(0, 0, 8'h00, 0, 8'hF7, 1, 0, 0);
    mk(0, 0, 8'h00, 1, 8'hBC, 1, 1, 0);
    // rd_pos=1 during first post-packet IDLE_K: /I1/ once, then /I2/
    mk(0, 0, 8'h00, 1, 8'hC5, 0, 0, 0);
    mk(0, 0, 8'h00, 1, 8'hBC, 1, 1, 0);
    mk(0, 0, 8'h00, 1, 8'h50, 0, 0, 0);
    mk(0, 0, 8'h00, 0, 8'hBC, 1, 1, 0);
    // 1-byte packet, tx_en rising in IDLE_K; R odd -> /T/R/
    mk(1, 0, 8'hAA, 0, 8'h50, 0, 0, 0);
    mk(1, 0, 8'h55, 0, 8'hFB, 1, 1, 1);
    mk(1, 0, 8'h11, 0, 8'h11, 0, 0, 1);
    mk(0, 0, 8'h00, 0, 8'hFD, 1, 1, 0);
    mk(0, 0, 8'h00, 0, 8'hF7, 1, 0, 0);
    mk(0, 0, 8'h00, 0, 8'hBC, 1, 1, 0);
    mk(0, 0, 8'h00, 0, 8'h50, 0, 0, 0);  // rd_pos=0 -> /I2/
    // 2-byte packet; R even -> /T/R/R/
    mk(1, 0, 8'h55, 0, 8'hFB, 1, 1, 1);
    mk(1, 0, 8'h21, 0, 8'h21, 0, 0, 1);
    mk(1, 0, 8'h22, 0, 8'h22, 0, 1, 1);
    mk(0, 0, 8'h00, 0, 8'hFD, 1, 0, 0);
    mk(0, 0, 8'h00, 0, 8'hF7, 1, 1, 0);
    mk(0, 0, 8'h00, 0, 8'hF7, 1, 0, 0);
    mk(0, 0, 8'h00, 0, 8'hBC, 1, 1, 0);
    mk(0, 0, 8'h00, 0, 8'h50, 0, 0, 0);
    // tx_er on 3rd data byte
    mk(1, 0, 8'h55, 0, 8'hFB, 1, 1, 1);
    mk(1, 0, 8'h31, 0, 8'h31, 0, 0, 1);
    mk(1, 0, 8'h32, 0, 8'h32, 0, 1, 1);
    mk(1, 1, 8'h33, 0, 8'hFE, 1, 0, 1);
    mk(1, 0, 8'h34, 0, 8'h34, 0, 1, 1);
    mk(0, 0, 8'h00, 0, 8'hFD, 1, 0, 0);
    mk(0, 0, 8'h00, 0, 8'hF7, 1, 1, 0);
    mk(0, 0, 8'h00, 0, 8'hF7, 1, 0, 0);
    mk(0, 0, 8'h00, 0, 8'hBC, 1, 1, 0);
    mk(0, 0, 8'h00, 0, 8'h50, 0, 0, 0);

    foreach (tbl[i]) begin
      tx_en = tbl[i].en; tx_er = tbl[i].er; txd = tbl[i].d; rd_pos = tbl[i].rd;
      step();
      chk("code", i, a_code, tbl[i].code);
      chk("k", i, {7'd0, a_k}, {7'd0, tbl[i].k});
      chk("even", i, {7'd0, a_even}, {7'd0, tbl[i].even});
      chk("transmitting", i, {7'd0, a_tr}, {7'd0, tbl[i].tr});
      exp_b = (tbl[i].code == 8'hC5) ? 8'h50 : tbl[i].code;
      chk("code_no_i1", i, b_code, exp_b);
    end

    // reset mid-DATA: next slot is BCh even, no /T/ afterwards
    tx_en = 1'b1; tx_er = 1'b0; txd = 8'h55; rd_pos = 1'b0;
    step();
    chk("mr_start", 0, a_code, 8'hFB);
    txd = 8'h41;
    step();
    chk("mr_data", 0, a_code, 8'h41);
    reset = 1'b0;
    step();
    chk("mr_code", 0, a_code, 8'hBC);
    chk("mr_k", 0, {7'd0, a_k}, 8'd1);
    chk("mr_even", 0, {7'd0, a_even}, 8'd1);
    chk("mr_tr", 0, {7'd0, a_tr}, 8'd0);
    reset = 1'b1; tx_en = 1'b0; rd_pos = 1'b1;
    step();
    chk("mr_post_idle", 0, a_code, 8'h50);  // no pending /I1/ after reset
    chk("mr_post_even", 0, {7'd0, a_even}, 8'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (a_code == 8'hFD) begin
        failures++;
        $display("FAIL mr_no_T cycle=%0d got=%h expected=not FD", i, a_code);
      end
    end

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
